// File: rtl/pc_unit_pkg.sv
// Shared opcode/funct constants, control-transfer kinds and PC-unit state encodings.
package pc_unit_pkg;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpRegimm  = 6'b000001;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] OpBlez    = 6'b000110;
  localparam logic [5:0] OpBgtz    = 6'b000111;

  localparam logic [5:0] FnJr      = 6'b001000;
  localparam logic [5:0] FnJalr    = 6'b001001;

  typedef enum logic [1:0] {
    KindNone,
    KindBranch,
    KindJump
  } pc_kind_e;

  typedef enum logic [1:0] {
    StFetch,
    StDecode,
    StWait
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-transfer target and kind decode for the fetched instruction.
module pc_target_calc
  import pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  output logic [31:0] target,
  output pc_kind_e    kind
);

  logic [31:0] branch_off;

  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    target = 32'h0;
    kind   = KindNone;
    unique case (instr[31:26])
      OpBeq, OpBne, OpBlez, OpBgtz, OpRegimm: begin
        target = pc + branch_off;
        kind   = KindBranch;
      end
      OpJ, OpJal: begin
        target = {pc[31:28], instr[25:0], 2'b00};
        kind   = KindJump;
      end
      OpSpecial: begin
        if (instr[5:0] == FnJr || instr[5:0] == FnJalr) begin
          target = rs_val;
          kind   = KindJump;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter sequencer: increments on fetch, decodes the target, and redirects on execute.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_done,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic        branch_succeed,
  input  logic        ex_done,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        pc_redirect,
  output logic        addr_err
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] target_q, target_d;
  pc_kind_e    kind_q, kind_d;
  logic [31:0] link_q, link_d;
  logic        redirect_q, redirect_d;
  logic        err_q, err_d;

  logic [31:0] calc_target;
  pc_kind_e    calc_kind;
  logic        take;

  // pc_q already points past the fetched instruction while decoding.
  pc_target_calc u_target_calc (
    .pc     (pc_q),
    .instr  (instr_q),
    .rs_val (rs_val),
    .target (calc_target),
    .kind   (calc_kind)
  );

  assign take = (kind_q == KindJump) || (kind_q == KindBranch && branch_succeed);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    target_d   = target_q;
    kind_d     = kind_q;
    link_d     = link_q;
    redirect_d = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      StFetch: begin
        if (fetch_done) begin
          pc_d    = pc_q + 32'd4;
          instr_d = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        target_d = calc_target;
        kind_d   = calc_kind;
        link_d   = pc_q + 32'd4;
        state_d  = StWait;
      end
      StWait: begin
        if (ex_done) begin
          if (take) begin
            if (target_q[1:0] != 2'b00) begin
              err_d = 1'b1;
            end else begin
              pc_d       = target_q;
              redirect_d = 1'b1;
            end
          end
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      target_q   <= 32'h0;
      kind_q     <= KindNone;
      link_q     <= 32'h0;
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      target_q   <= target_d;
      kind_q     <= kind_d;
      link_q     <= link_d;
      redirect_q <= redirect_d;
      err_q      <= err_d;
    end
  end

  assign pc          = pc_q;
  assign link_addr   = link_q;
  assign pc_redirect = redirect_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: fetch/decode/execute sequences with hand-computed expectations.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_done = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs_val = 32'h0;
  logic        branch_succeed = 1'b0;
  logic        ex_done = 1'b0;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        pc_redirect;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Nop   = 32'h0000_0000;
  localparam logic [31:0] J100  = 32'h0800_0040;
  localparam logic [31:0] Jal40 = 32'h0C00_0040;
  localparam logic [31:0] BeqM2 = 32'h1000_FFFE;
  localparam logic [31:0] Jr    = 32'h0000_0008;
  localparam logic [31:0] Jalr  = 32'h0000_0009;

  pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_done     (fetch_done),
    .instr          (instr),
    .rs_val         (rs_val),
    .branch_succeed (branch_succeed),
    .ex_done        (ex_done),
    .pc             (pc),
    .link_addr      (link_addr),
    .pc_redirect    (pc_redirect),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] iw);
    @(negedge clk);
    fetch_done = 1'b1;
    instr = iw;
    @(posedge clk);
    #1;
    fetch_done = 1'b0;
  endtask

  task automatic decode(input logic [31:0] rs);
    @(negedge clk);
    rs_val = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic execute(input logic bs);
    @(negedge clk);
    ex_done = 1'b1;
    branch_succeed = bs;
    @(posedge clk);
    #1;
    ex_done = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_link", link_addr, 32'h0);
    check("rst_redir", {31'b0, pc_redirect}, 32'h0);
    check("rst_err", {31'b0, addr_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // NOP: plain increment, no redirect
    fetch(Nop);
    check("nop_pc", pc, 32'h4);
    decode(32'h0);
    execute(1'b1);
    check("nop_pc_ex", pc, 32'h4);
    check("nop_redir", {31'b0, pc_redirect}, 32'h0);

    // J to 0x100
    fetch(J100);
    decode(32'h0);
    execute(1'b0);
    check("j_pc", pc, 32'h100);
    check("j_redir", {31'b0, pc_redirect}, 32'h1);
    idle();
    check("j_redir_drop", {31'b0, pc_redirect}, 32'h0);
    check("j_hold", pc, 32'h100);

    // BEQ taken backwards
    fetch(BeqM2);
    check("beq_inc", pc, 32'h104);
    decode(32'h0);
    execute(1'b1);
    check("beq_t_pc", pc, 32'h0FC);
    check("beq_t_redir", {31'b0, pc_redirect}, 32'h1);
    idle();
    check("beq_t_drop", {31'b0, pc_redirect}, 32'h0);

    // Back to 0x100, then BEQ not taken
    fetch(J100);
    decode(32'h0);
    execute(1'b0);
    fetch(BeqM2);
    decode(32'h0);
    execute(1'b0);
    check("beq_nt_pc", pc, 32'h104);
    check("beq_nt_redir", {31'b0, pc_redirect}, 32'h0);

    // JR to 0x4000_0010, then JAL
    fetch(Jr);
    decode(32'h4000_0010);
    execute(1'b0);
    check("jr_pc", pc, 32'h4000_0010);
    fetch(Jal40);
    decode(32'h0);
    check("jal_link", link_addr, 32'h4000_0018);
    execute(1'b0);
    check("jal_pc", pc, 32'h4000_0100);
    check("jal_redir", {31'b0, pc_redirect}, 32'h1);

    // ex_done in fetch state is ignored
    execute(1'b1);
    check("exfetch_pc", pc, 32'h4000_0100);
    check("exfetch_redir", {31'b0, pc_redirect}, 32'h0);

    // Misaligned JR
    fetch(Jr);
    decode(32'h0000_0202);
    execute(1'b0);
    check("mis_pc", pc, 32'h4000_0104);
    check("mis_err", {31'b0, addr_err}, 32'h1);
    check("mis_redir", {31'b0, pc_redirect}, 32'h0);

    // JALR to 0xFFFF_FFFC
    fetch(Jalr);
    decode(32'hFFFF_FFFC);
    check("jalr_link", link_addr, 32'h4000_010C);
    execute(1'b0);
    check("jalr_pc", pc, 32'hFFFF_FFFC);

    // Wrap, with fetch_done held high through decode and wait
    @(negedge clk);
    fetch_done = 1'b1;
    instr = Nop;
    idle();
    check("wrap_pc", pc, 32'h0);
    idle();
    idle();
    check("held_pc", pc, 32'h0);
    @(negedge clk);
    fetch_done = 1'b0;
    ex_done = 1'b1;
    @(posedge clk);
    #1;
    ex_done = 1'b0;
    check("held_pc_ex", pc, 32'h0);
    check("err_sticky", {31'b0, addr_err}, 32'h1);

    // Reset with a pending taken branch to 0xFFFF_FFFC
    fetch(BeqM2);
    decode(32'h0);
    @(negedge clk);
    branch_succeed = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_err", {31'b0, addr_err}, 32'h0);
    check("arst_link", link_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    execute(1'b1);
    check("post_rst_pc", pc, 32'h0);
    check("post_rst_redir", {31'b0, pc_redirect}, 32'h0);
    fetch(Nop);
    check("post_rst_fetch", pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port fetch_done  input  1  CU strobe: instruction register loaded this cycle.
REQ-005 SHALL have port instr  input  32  current instruction word, valid when fetch_done=1.
REQ-006 SHALL have port rs_val  input  32  register-file rs read value, valid in S_DECODE.
REQ-007 SHALL have port branch_succeed  input  1  branch-condition result from the branch unit, updated on negedge clk.
REQ-008 SHALL have port ex_done  input  1  CU strobe: execute phase complete, PC may be written.
REQ-009 SHALL have port pc  output  32  current program counter.
REQ-010 SHALL have port link_addr  output  32  return address (PC of the instruction plus 8) for JAL/JALR.
REQ-011 SHALL have port pc_redirect  output  1  one-cycle pulse when a taken branch or jump writes pc.
REQ-012 SHALL have port addr_err  output  1  sticky flag: misaligned control-transfer target.

Function
REQ-013 SHALL implement states S_FETCH, S_DECODE, S_WAIT; reset state S_FETCH.
REQ-014 In S_FETCH with fetch_done=1: pc <= pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), latch instr, go S_DECODE; fetch_done=0 holds.
REQ-015 In S_DECODE: compute and register target and kind, link_addr <= pc+4 (that is, the instruction's PC+8), go S_WAIT unconditionally.
REQ-016 Branch kinds (BEQ, BNE, BLEZ, BGTZ, and opcode 000001 BLTZ/BGEZ): target = pc + (sign-extend(instr[15:0]) << 2), 32-bit modulo.
REQ-017 J/JAL: target = {pc[31:28], instr[25:0], 2'b00}; JR (opcode 0, funct 001000) and JALR (funct 001001): target = rs_val.
REQ-018 All other instructions: kind NONE; pc is never redirected.
REQ-019 In S_WAIT with ex_done=1: jump kinds always write pc <= target, branch kinds write only if branch_succeed=1, then go S_FETCH.
REQ-020 In S_WAIT with ex_done=0: hold pc and all state.
REQ-021 pc_redirect SHALL assert exactly in the cycle after a target write and deassert the next cycle.
REQ-022 If target[1:0]!=0 at a would-be write: pc unchanged, no redirect, addr_err <= 1 (cleared only by reset), return to S_FETCH.
REQ-023 fetch_done in S_DECODE or S_WAIT SHALL be ignored; ex_done in S_FETCH or S_DECODE SHALL be ignored.
REQ-024 branch_succeed SHALL be sampled only at the posedge where S_WAIT and ex_done=1 (it is stable since the prior negedge).

Reset
REQ-025 On rst_n low, asynchronously: pc=RESET_PC, link_addr=0, pc_redirect=0, addr_err=0, state=S_FETCH, latched instr/target=0.
REQ-026 Reset mid-instruction SHALL discard any pending target; the first post-reset fetch uses RESET_PC.

Structure
REQ-027 Opcode/funct constants and state encodings SHALL live in shared header cpu_defs.vh, also used by CU and branch unit.
REQ-028 Target arithmetic SHALL be one combinational sub-module pc_target_calc (inputs pc, instr, rs_val; outputs target, kind).

Verification
REQ-029 Reset, then fetch_done with NOP -> pc=0x4, no pc_redirect after ex_done.
REQ-030 pc=0x100, BEQ imm=0xFFFE, branch_succeed=1 at ex_done -> pc=0x0FC, pc_redirect pulse 1 cycle; same with branch_succeed=0 -> pc=0x104.
REQ-031 pc=0x4000_0010, JAL index 0x000_0040 -> pc=0x4000_0100, link_addr=0x4000_0018.
REQ-032 JR with rs_val=0x0000_0202 -> pc unchanged, addr_err=1, no redirect.
REQ-033 pc=0xFFFF_FFFC, fetch_done -> pc=0x0000_0000; fetch_done held high through S_WAIT -> no extra increment.
REQ-034 rst_n low in S_WAIT with a pending taken branch -> pc=RESET_PC immediately, no redirect after release.
